// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and widths for the game-end sequencer
// Purpose: state encoding of the game-end FSM and the score width that is
//          shared with the score counter and the end-screen renderer.
// Ports:   none (package).

package game_pkg;

    localparam int SCORE_W = 16;

    // Encoding is fixed: the state code is exported on a debug port.
    typedef enum logic [2:0] {
        ST_PLAY      = 3'd0,
        ST_DYING     = 3'd1,
        ST_END_WAIT  = 3'd2,
        ST_END_READY = 3'd3,
        ST_RESTART   = 3'd4
    } game_state_e;

endpackage

// File: rtl/game_over_ctrl_if.sv
// rtl/game_over_ctrl_if.sv - signal bundle between game logic and the game-end sequencer
// Purpose: groups the frame/event/key inputs and the end-screen outputs.
// Ports:   master drives startOfFrame, playerDead, invadersLanded, score,
//          keyStart, keyCredit and observes the outputs;
//          slave (the sequencer) drives gameEnded, newHighScore, highScore,
//          showCredits, restartGame, state.

interface game_over_ctrl_if #(
    parameter int SCORE_W = game_pkg::SCORE_W
);
    logic               startOfFrame;
    logic               playerDead;
    logic               invadersLanded;
    logic [SCORE_W-1:0] score;
    logic               keyStart;
    logic               keyCredit;
    logic               gameEnded;
    logic               newHighScore;
    logic [SCORE_W-1:0] highScore;
    logic               showCredits;
    logic               restartGame;
    logic [2:0]         state;

    modport master (
        output startOfFrame, playerDead, invadersLanded, score, keyStart, keyCredit,
        input  gameEnded, newHighScore, highScore, showCredits, restartGame, state
    );

    modport slave (
        input  startOfFrame, playerDead, invadersLanded, score, keyStart, keyCredit,
        output gameEnded, newHighScore, highScore, showCredits, restartGame, state
    );
endinterface

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - registered rising-edge detector for one key level
// Purpose: turns a debounced key level into a one-cycle registered press.
// Ports:   clk, reset (sync, active-high), key_in (level), press (1-cycle pulse,
//          one cycle after the rising edge of key_in).

module key_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic press
);

    logic key_q, key_d;
    logic press_q, press_d;

    always_comb begin
        key_d   = key_in;
        press_d = key_in & ~key_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            key_q   <= key_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/game_over_ctrl.sv
// rtl/game_over_ctrl.sv - game-end sequencer feeding the end-screen renderer
// Purpose: detects game end, waits out the death animation, latches the
//          high-score comparison, holds off keys for a lockout period, then
//          handles credit-page toggling and restart.
// Ports:   clk, reset (sync, active-high);
//          bus (game_over_ctrl_if.slave): startOfFrame, playerDead,
//          invadersLanded, score, keyStart, keyCredit in; gameEnded,
//          newHighScore, highScore, showCredits, restartGame, state out.
//          All outputs are registered.

module game_over_ctrl #(
    parameter int SCORE_W        = game_pkg::SCORE_W,
    parameter int DEATH_FRAMES   = 60,
    parameter int LOCKOUT_FRAMES = 30,
    parameter int FCNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    game_over_ctrl_if.slave  bus
);
    import game_pkg::*;

    localparam logic [FCNT_W-1:0] DEATH_LAST = FCNT_W'(DEATH_FRAMES - 1);
    localparam logic [FCNT_W-1:0] LOCK_LAST  = FCNT_W'(LOCKOUT_FRAMES - 1);

    logic start_press;
    logic credit_press;

    // Key history runs in every state so a key held through lockout
    // never shows up as a press once END_READY is reached.
    key_edge_detect u_start_edge (
        .clk    (clk),
        .reset  (reset),
        .key_in (bus.keyStart),
        .press  (start_press)
    );

    key_edge_detect u_credit_edge (
        .clk    (clk),
        .reset  (reset),
        .key_in (bus.keyCredit),
        .press  (credit_press)
    );

    game_state_e        state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               game_ended_q, game_ended_d;
    logic               new_high_q, new_high_d;
    logic [SCORE_W-1:0] high_score_q, high_score_d;
    logic               show_credits_q, show_credits_d;
    logic               restart_q, restart_d;

    always_comb begin
        state_d        = state_q;
        fcnt_d         = fcnt_q;
        game_ended_d   = game_ended_q;
        new_high_d     = new_high_q;
        high_score_d   = high_score_q;
        show_credits_d = show_credits_q;
        restart_d      = 1'b0;

        case (state_q)
            ST_PLAY: begin
                if (bus.playerDead | bus.invadersLanded) begin
                    state_d = ST_DYING;
                    fcnt_d  = '0;
                end
            end

            ST_DYING: begin
                if (bus.startOfFrame) begin
                    if (fcnt_q == DEATH_LAST) begin
                        state_d      = ST_END_WAIT;
                        fcnt_d       = '0;
                        game_ended_d = 1'b1;
                        // Strict compare: tying the record is not a new record.
                        if (bus.score > high_score_q) begin
                            high_score_d = bus.score;
                            new_high_d   = 1'b1;
                        end else begin
                            new_high_d   = 1'b0;
                        end
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end

            ST_END_WAIT: begin
                if (bus.startOfFrame) begin
                    if (fcnt_q == LOCK_LAST) begin
                        state_d = ST_END_READY;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
            end

            ST_END_READY: begin
                // Start wins over a simultaneous credit press.
                if (start_press) begin
                    state_d   = ST_RESTART;
                    restart_d = 1'b1;
                end else if (credit_press) begin
                    show_credits_d = ~show_credits_q;
                end
            end

            ST_RESTART: begin
                state_d        = ST_PLAY;
                game_ended_d   = 1'b0;
                new_high_d     = 1'b0;
                show_credits_d = 1'b0;
            end

            default: begin
                state_d = ST_PLAY;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_PLAY;
            fcnt_q         <= '0;
            game_ended_q   <= 1'b0;
            new_high_q     <= 1'b0;
            high_score_q   <= '0;
            show_credits_q <= 1'b0;
            restart_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            fcnt_q         <= fcnt_d;
            game_ended_q   <= game_ended_d;
            new_high_q     <= new_high_d;
            high_score_q   <= high_score_d;
            show_credits_q <= show_credits_d;
            restart_q      <= restart_d;
        end
    end

    assign bus.gameEnded    = game_ended_q;
    assign bus.newHighScore = new_high_q;
    assign bus.highScore    = high_score_q;
    assign bus.showCredits  = show_credits_q;
    assign bus.restartGame  = restart_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_game_over_ctrl.sv
// tb/tb_game_over_ctrl.sv - scoreboard bench for game_over_ctrl

module tb_game_over_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_over_ctrl_if #(.SCORE_W(16)) bus ();

    game_over_ctrl #(
        .SCORE_W        (16),
        .DEATH_FRAMES   (60),
        .LOCKOUT_FRAMES (30),
        .FCNT_W         (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [2:0]  st;
        logic        ge;
        logic        nhs;
        logic [15:0] hs;
        logic        sc;
        logic        rg;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    // Expected output image, edited by the stimulus before each push.
    logic [2:0]  m_st  = 3'd0;
    logic        m_ge  = 1'b0;
    logic        m_nhs = 1'b0;
    logic [15:0] m_hs  = 16'd0;
    logic        m_sc  = 1'b0;
    logic        m_rg  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int at);
        exp_t e;
        e.cyc = at; e.st = m_st; e.ge = m_ge; e.nhs = m_nhs;
        e.hs = m_hs; e.sc = m_sc; e.rg = m_rg;
        exp_q.push_back(e);
    endfunction

    // Monitor: any change on an output is an event and must match the
    // next expected entry, including the cycle it appears on.
    logic [2:0]  p_st;
    logic        p_ge, p_nhs, p_sc, p_rg;
    logic [15:0] p_hs;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && (bus.state !== p_st || bus.gameEnded !== p_ge ||
                       bus.newHighScore !== p_nhs || bus.highScore !== p_hs ||
                       bus.showCredits !== p_sc || bus.restartGame !== p_rg)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d st=%0d ge=%b nhs=%b hs=%0d sc=%b rg=%b",
                         cyc, bus.state, bus.gameEnded, bus.newHighScore,
                         bus.highScore, bus.showCredits, bus.restartGame);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || bus.state !== e.st || bus.gameEnded !== e.ge ||
                    bus.newHighScore !== e.nhs || bus.highScore !== e.hs ||
                    bus.showCredits !== e.sc || bus.restartGame !== e.rg) begin
                    failures++;
                    $display("FAIL event got/exp cyc=%0d/%0d st=%0d/%0d ge=%b/%b nhs=%b/%b hs=%0d/%0d sc=%b/%b rg=%b/%b",
                             cyc, e.cyc, bus.state, e.st, bus.gameEnded, e.ge,
                             bus.newHighScore, e.nhs, bus.highScore, e.hs,
                             bus.showCredits, e.sc, bus.restartGame, e.rg);
                end
            end
        end
        p_st = bus.state; p_ge = bus.gameEnded; p_nhs = bus.newHighScore;
        p_hs = bus.highScore; p_sc = bus.showCredits; p_rg = bus.restartGame;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic start_game(input logic [15:0] sc, input logic pd, input logic il);
        bus.score          = sc;
        bus.playerDead     = pd;
        bus.invadersLanded = il;
        m_st = 3'd1;
        push(cyc + 1);
        tick();
        bus.playerDead     = 1'b0;
        bus.invadersLanded = 1'b0;
    endtask

    // Final death frame: END_WAIT entry with the latched high-score result.
    task automatic death_end(input logic exp_nhs, input logic [15:0] exp_hs);
        m_st = 3'd2; m_ge = 1'b1; m_nhs = exp_nhs; m_hs = exp_hs;
        push(cyc + 1);
        frame();
    endtask

    task automatic lockout();
        frames(29);
        m_st = 3'd3;
        push(cyc + 1);
        frame();
    endtask

    task automatic press_credit();
        bus.keyCredit = 1'b1;
        m_sc = ~m_sc;
        push(cyc + 2);
        tick();
        bus.keyCredit = 1'b0;
        tick();
        tick();
    endtask

    task automatic press_start(input logic with_credit);
        bus.keyStart  = 1'b1;
        bus.keyCredit = with_credit;
        m_st = 3'd4; m_rg = 1'b1;
        push(cyc + 2);
        m_st = 3'd0; m_rg = 1'b0; m_ge = 1'b0; m_nhs = 1'b0; m_sc = 1'b0;
        push(cyc + 3);
        tick();
        bus.keyStart  = 1'b0;
        bus.keyCredit = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.startOfFrame = 1'b0; bus.playerDead = 1'b0; bus.invadersLanded = 1'b0;
        bus.score = 16'd0; bus.keyStart = 1'b0; bus.keyCredit = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();

        chk("rst_state", {13'd0, bus.state}, 16'd0);
        chk("rst_gameEnded", {15'd0, bus.gameEnded}, 16'd0);
        chk("rst_newHighScore", {15'd0, bus.newHighScore}, 16'd0);
        chk("rst_highScore", bus.highScore, 16'd0);
        chk("rst_showCredits", {15'd0, bus.showCredits}, 16'd0);
        chk("rst_restartGame", {15'd0, bus.restartGame}, 16'd0);
        mon_en = 1'b1;

        // Game 1: first score beats the reset high score.
        start_game(16'd1200, 1'b1, 1'b0);
        frames(59);
        death_end(1'b1, 16'd1200);
        lockout();
        press_credit();
        press_credit();
        press_start(1'b0);

        // Game 2: lower score; then simultaneous start+credit with credits shown.
        start_game(16'd800, 1'b1, 1'b0);
        frames(59);
        death_end(1'b0, 16'd1200);
        lockout();
        press_credit();
        press_start(1'b1);

        // Game 3: equal score; start key held from DYING through lockout.
        start_game(16'd1200, 1'b1, 1'b0);
        bus.keyStart = 1'b1;
        frames(59);
        death_end(1'b0, 16'd1200);
        lockout();
        tick(); tick();
        bus.keyStart = 1'b0;
        tick(); tick();
        press_start(1'b0);

        // Game 4: both triggers together, re-trigger mid-DYING.
        start_game(16'd500, 1'b1, 1'b1);
        frames(20);
        bus.invadersLanded = 1'b1;
        tick(); tick(); tick();
        bus.invadersLanded = 1'b0;
        frames(39);
        death_end(1'b0, 16'd1200);
        lockout();
        press_start(1'b0);

        // Game 5: reset during END_WAIT at frame 10 clears the high score.
        start_game(16'd2000, 1'b0, 1'b1);
        frames(59);
        death_end(1'b1, 16'd2000);
        frames(10);
        reset = 1'b1;
        m_st = 3'd0; m_ge = 1'b0; m_nhs = 1'b0; m_hs = 16'd0; m_sc = 1'b0; m_rg = 1'b0;
        push(cyc + 1);
        tick();
        reset = 1'b0;
        tick(); tick();

        // Game 6: a small score is a record again after reset.
        start_game(16'd100, 1'b1, 1'b0);
        frames(59);
        death_end(1'b1, 16'd100);
        lockout();
        press_start(1'b0);

        tick(); tick(); tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events got=%0d pending exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
